regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (we3/a3/wd3) between NREQ writeback requesters, e.g. ALU writeback, load unit and a multi-cycle mul/div unit.
- Arbitrates round-robin under a valid/ready handshake and stages the winning write in one register stage. The regfile captures that write on the following falling clock edge.
- Also exports a pending-write bitmap so hazard/stall logic can see registers whose writes have not yet landed.

Parameters:
NREQ, 3, number of writeback requesters (2..8)
XLEN, 32, data width
AW, 5, register address width

Ports:
clk  in  1  system clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
wb_en  in  1  global writeback enable; 0 = no grants
req_valid  in  NREQ  requester i has a write pending
req_rd  in  NREQ*AW  destination register of requester i, bits [i*AW +: AW]
req_data  in  NREQ*XLEN  write data of requester i, bits [i*XLEN +: XLEN]
req_ready  out  NREQ  one-hot grant; transfer when req_valid[i] & req_ready[i]
rf_we  out  1  to regfile we3
rf_a3  out  AW  to regfile a3
rf_wd  out  XLEN  to regfile wd3
pending  out  2**AW  bit r = 1 if a write to register r is requested or staged; bit 0 always 0
grant_idx  out  clog2(NREQ)  index of last accepted requester (debug)

Behaviour:
- Reset (rst_n=0, asynchronous):
  - rf_we=0, rf_a3=0, rf_wd=0, grant_idx=0, RR pointer=0.
  - req_ready=0 while reset is asserted.
  - A staged write is discarded. No regfile write occurs for it.
- Grant (combinational, same cycle):
  - If wb_en=1 and any req_valid is set, req_ready goes one-hot on the first valid requester at or after the RR pointer, searching upward with wrap at NREQ.
  - Otherwise req_ready=0.
  - req_ready never asserts on an invalid requester.
- Transfer and latency:
  - A handshake in cycle t loads rf_we/rf_a3/rf_wd at the rising edge ending t.
  - The regfile writes at the falling edge of cycle t+1, so the write completes 1.5 cycles after the handshake.
  - rf_we=1 exactly one cycle per accepted transfer, unless rd=0.
  - With no transfer, rf_we=0 at the next edge.
- x0 rule: a request with rd=0 is accepted normally (ready asserted, pointer advances). The staged rf_we is forced to 0.
- RR pointer: after a grant to i, pointer <= (i+1) mod NREQ. It is unchanged when there is no grant. Every continuously valid requester is granted within NREQ cycles.
- Requester rules:
  - Once req_valid is asserted it holds, with stable rd/data, until the handshake.
  - The arbiter never reorders writes from the same requester.
  - Ordering between different requesters targeting the same rd in the same cycle is RR order. Upstream stall logic must prevent such WAW conflicts.
- wb_en=0:
  - req_ready=0.
  - rf_we clears at the next edge; an already-staged write still lands on that cycle's falling edge.
  - The RR pointer holds.
- pending, combinational:
  - OR over all i of (req_valid[i] ? onehot(req_rd[i]) : 0), ORed with (rf_we ? onehot(rf_a3) : 0).
  - Bit 0 is masked to 0.
  - pending is 0 during reset.
- Single write port: at most one rf_we pulse per cycle regardless of NREQ.

Decomposition:
- Shared package rf_pkg holds:
  - XLEN=32, AW=5, NREG=32;
  - the rf_wb_req_t struct {valid, rd, data};
  - the function onehot_rd(rd) returning an NREG-bit decode.
- One natural sub-module: rr_arbiter (NREQ parameter). It takes a request vector, the pointer and an enable, and produces the one-hot grant and the encoded index. It is reused by future CSR and memory-port arbiters.

Test Plan:
- Reset, then a single request: req_valid=001, rd=5, data=0xDEADBEEF.
  - req_ready=001 the same cycle.
  - rf_we=1, rf_a3=5, rf_wd=0xDEADBEEF the next cycle.
  - The regfile read of x5 returns 0xDEADBEEF after the falling edge.
- All three valid continuously: rd=1/2/3, data=0x11/0x22/0x33.
  - Grants in order 0,1,2 on consecutive cycles.
  - rf_a3 sequence 1,2,3, one per cycle.
  - The pointer then wraps to 0.
- x0 write: requester 1 issues rd=0, data=0xFFFFFFFF.
  - Handshake occurs, rf_we stays 0, pointer advances to 2.
  - x0 still reads 0.
- pending check: requesters 0 and 2 valid with rd=7 and rd=9.
  - pending has bits 7 and 9 set.
  - After both grants and staging clear, pending=0.
- wb_en=0 for 4 cycles with req_valid=111.
  - req_ready=000 and rf_we=0 throughout.
  - When wb_en=1 the grant starts at the held pointer.
- rst_n pulled low asynchronously mid-cycle with rf_we=1 staged for rd=10.
  - rf_we drops immediately, x10 is unchanged, and pending=0.
  - After release, the first grant goes to requester 0.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared register-file definitions for writeback arbitration and future
// CSR / memory-port arbiters.
package rf_pkg;

   localparam int XLEN = 32;
   localparam int AW   = 5;
   localparam int NREG = 32;

   typedef struct packed {
      logic            valid;
      logic [AW-1:0]   rd;
      logic [XLEN-1:0] data;
   } rf_wb_req_t;

   function automatic logic [NREG-1:0] onehot_rd(input logic [AW-1:0] rd);
      onehot_rd = NREG'(1) << rd;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after ptr_i,
// searching upward with wrap at NREQ.
module rr_arbiter #(
   parameter  int NREQ = 3,
   localparam int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IW-1:0]   ptr_i,
   input  logic            en_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [IW-1:0]   idx_o
);

   logic        found;
   logic [IW:0] cand;

   // One extra bit on the candidate lets ptr+k exceed NREQ before wrapping.
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      cand  = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = {1'b0, ptr_i} + (IW+1)'(k);
         if (cand >= (IW+1)'(NREQ)) begin
            cand = cand - (IW+1)'(NREQ);
         end
         if (en_i && !found && req_i[cand[IW-1:0]]) begin
            found                = 1'b1;
            gnt_o[cand[IW-1:0]]  = 1'b1;
            idx_o                = cand[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the single regfile write port between NREQ writeback requesters,
// staging the round-robin winner in one register stage.
module regfile_wb_arbiter
   import rf_pkg::*;
#(
   parameter int NREQ = 3,
   parameter int XLEN = rf_pkg::XLEN,
   parameter int AW   = rf_pkg::AW
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wb_en,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ*AW-1:0]       req_rd,
   input  logic [NREQ*XLEN-1:0]     req_data,
   output logic [NREQ-1:0]          req_ready,
   output logic                     rf_we,
   output logic [AW-1:0]            rf_a3,
   output logic [XLEN-1:0]          rf_wd,
   output logic [2**AW-1:0]         pending,
   output logic [$clog2(NREQ)-1:0]  grant_idx
);

   localparam int IW = $clog2(NREQ);
   localparam int NR = 2**AW;

   logic [NREQ-1:0] gnt;
   logic [IW-1:0]   win_idx;
   logic [AW-1:0]   win_rd;
   logic [XLEN-1:0] win_data;
   logic            arb_en;

   logic [IW-1:0]   ptr_q, ptr_d;
   logic [IW-1:0]   grant_idx_q, grant_idx_d;
   logic            rf_we_q, rf_we_d;
   logic [AW-1:0]   rf_a3_q, rf_a3_d;
   logic [XLEN-1:0] rf_wd_q, rf_wd_d;
   logic [NR-1:0]   pend;

   // Gating with rst_n keeps ready low for the whole time reset is held.
   assign arb_en = wb_en & rst_n;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req_i (req_valid),
      .ptr_i (ptr_q),
      .en_i  (arb_en),
      .gnt_o (gnt),
      .idx_o (win_idx)
   );

   assign win_rd   = req_rd[win_idx*AW +: AW];
   assign win_data = req_data[win_idx*XLEN +: XLEN];

   // A grant to x0 still completes the handshake but never raises rf_we.
   always_comb begin
      ptr_d       = ptr_q;
      grant_idx_d = grant_idx_q;
      rf_we_d     = 1'b0;
      rf_a3_d     = rf_a3_q;
      rf_wd_d     = rf_wd_q;
      if (|gnt) begin
         rf_we_d     = (win_rd != '0);
         rf_a3_d     = win_rd;
         rf_wd_d     = win_data;
         grant_idx_d = win_idx;
         ptr_d       = (win_idx == IW'(NREQ-1)) ? '0 : win_idx + IW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q       <= '0;
         grant_idx_q <= '0;
         rf_we_q     <= 1'b0;
         rf_a3_q     <= '0;
         rf_wd_q     <= '0;
      end else begin
         ptr_q       <= ptr_d;
         grant_idx_q <= grant_idx_d;
         rf_we_q     <= rf_we_d;
         rf_a3_q     <= rf_a3_d;
         rf_wd_q     <= rf_wd_d;
      end
   end

   always_comb begin
      pend = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (req_valid[i]) begin
            pend = pend | (NR'(1) << req_rd[i*AW +: AW]);
         end
      end
      if (rf_we_q) begin
         pend = pend | (NR'(1) << rf_a3_q);
      end
      pend[0] = 1'b0;
      if (!rst_n) begin
         pend = '0;
      end
   end

   assign req_ready = gnt;
   assign rf_we     = rf_we_q;
   assign rf_a3     = rf_a3_q;
   assign rf_wd     = rf_wd_q;
   assign grant_idx = grant_idx_q;
   assign pending   = pend;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter with a falling-edge
// regfile model standing in for the real register file.
module tb_regfile_wb_arbiter;

   localparam int NREQ = 3;
   localparam int XLEN = 32;
   localparam int AW   = 5;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 wb_en;
   logic [NREQ-1:0]      req_valid;
   logic [AW-1:0]        rdArr   [NREQ];
   logic [XLEN-1:0]      dataArr [NREQ];
   logic [NREQ*AW-1:0]   req_rd;
   logic [NREQ*XLEN-1:0] req_data;
   logic [NREQ-1:0]      req_ready;
   logic                 rf_we;
   logic [AW-1:0]        rf_a3;
   logic [XLEN-1:0]      rf_wd;
   logic [2**AW-1:0]     pending;
   logic [1:0]           grant_idx;

   logic [XLEN-1:0]      rfMem [32];
   int                   assertCount = 0;
   int                   failCount   = 0;
   int                   rowNum      = 0;

   assign req_rd   = {rdArr[2], rdArr[1], rdArr[0]};
   assign req_data = {dataArr[2], dataArr[1], dataArr[0]};

   always #5 clk = ~clk;

   // Regfile captures the staged write on the falling edge.
   always @(negedge clk) begin
      if (rf_we) rfMem[rf_a3] <= rf_wd;
   end

   regfile_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wb_en     (wb_en),
      .req_valid (req_valid),
      .req_rd    (req_rd),
      .req_data  (req_data),
      .req_ready (req_ready),
      .rf_we     (rf_we),
      .rf_a3     (rf_a3),
      .rf_wd     (rf_wd),
      .pending   (pending),
      .grant_idx (grant_idx)
   );

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Entered just after a rising edge: drive, check combinational outputs,
   // then check the staged write after the next rising edge.
   task automatic applyStimulus(input logic [2:0] v, input logic en, input logic [2:0] expReady,
                                input logic [31:0] expPend, input logic expWe,
                                input logic [AW-1:0] expA3, input logic [31:0] expWd);
      rowNum++;
      req_valid = v;
      wb_en     = en;
      #2;
      checkOutput($sformatf("r%0d_ready", rowNum), 64'(req_ready), 64'(expReady));
      checkOutput($sformatf("r%0d_pending", rowNum), 64'(pending), 64'(expPend));
      @(posedge clk);
      #1;
      checkOutput($sformatf("r%0d_rf_we", rowNum), 64'(rf_we), 64'(expWe));
      if (expWe) begin
         checkOutput($sformatf("r%0d_rf_a3", rowNum), 64'(rf_a3), 64'(expA3));
         checkOutput($sformatf("r%0d_rf_wd", rowNum), 64'(rf_wd), 64'(expWd));
      end
      if (expReady != 3'b000) begin
         checkOutput($sformatf("r%0d_grant_idx", rowNum), 64'(grant_idx),
                     expReady[2] ? 64'd2 : (expReady[1] ? 64'd1 : 64'd0));
      end
   endtask

   task automatic setReqs(input logic [AW-1:0] r0, r1, r2, input logic [31:0] d0, d1, d2);
      rdArr[0] = r0; rdArr[1] = r1; rdArr[2] = r2;
      dataArr[0] = d0; dataArr[1] = d1; dataArr[2] = d2;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      for (int r = 0; r < 32; r++) rfMem[r] = '0;
      rst_n     = 1'b0;
      wb_en     = 1'b1;
      req_valid = 3'b111;
      setReqs(5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33);

      // Reset state, with requests present
      #7;
      checkOutput("rst_ready", 64'(req_ready), 64'h0);
      checkOutput("rst_pending", 64'(pending), 64'h0);
      checkOutput("rst_rf_we", 64'(rf_we), 64'h0);
      checkOutput("rst_rf_a3", 64'(rf_a3), 64'h0);
      checkOutput("rst_rf_wd", 64'(rf_wd), 64'h0);
      checkOutput("rst_grant_idx", 64'(grant_idx), 64'h0);
      req_valid = 3'b000;
      #3 rst_n = 1'b1;
      @(posedge clk); #1;

      // Single request, write lands on the following falling edge
      setReqs(5'd5, 5'd2, 5'd3, 32'hDEADBEEF, 32'h22, 32'h33);
      applyStimulus(3'b001, 1'b1, 3'b001, 32'h20, 1'b1, 5'd5, 32'hDEADBEEF);
      req_valid = 3'b000;
      @(negedge clk); #1;
      checkOutput("x5_read", 64'(rfMem[5]), 64'hDEADBEEF);
      @(posedge clk); #1;
      checkOutput("idle_rf_we", 64'(rf_we), 64'h0);
      checkOutput("idle_pending", 64'(pending), 64'h0);

      // Reset again so the round-robin sequence starts at pointer 0
      @(negedge clk) rst_n = 1'b0;
      #2 rst_n = 1'b1;
      @(posedge clk); #1;

      setReqs(5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33);
      applyStimulus(3'b111, 1'b1, 3'b001, 32'hE, 1'b1, 5'd1, 32'h11);
      applyStimulus(3'b110, 1'b1, 3'b010, 32'hE, 1'b1, 5'd2, 32'h22);
      applyStimulus(3'b100, 1'b1, 3'b100, 32'hC, 1'b1, 5'd3, 32'h33);
      applyStimulus(3'b101, 1'b1, 3'b001, 32'hA, 1'b1, 5'd1, 32'h11);
      applyStimulus(3'b100, 1'b1, 3'b100, 32'hA, 1'b1, 5'd3, 32'h33);

      // x0 write: handshake, no rf_we, pointer moves to 2
      setReqs(5'd1, 5'd0, 5'd3, 32'h11, 32'hFFFFFFFF, 32'h33);
      applyStimulus(3'b010, 1'b1, 3'b010, 32'h8, 1'b0, 5'd0, 32'h0);
      setReqs(5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33);
      applyStimulus(3'b111, 1'b1, 3'b100, 32'hE, 1'b1, 5'd3, 32'h33);
      applyStimulus(3'b011, 1'b1, 3'b001, 32'hE, 1'b1, 5'd1, 32'h11);
      applyStimulus(3'b010, 1'b1, 3'b010, 32'h6, 1'b1, 5'd2, 32'h22);
      applyStimulus(3'b000, 1'b1, 3'b000, 32'h4, 1'b0, 5'd0, 32'h0);

      // pending bitmap for x7 and x9
      setReqs(5'd7, 5'd2, 5'd9, 32'h11, 32'h22, 32'h33);
      applyStimulus(3'b101, 1'b1, 3'b100, 32'h280, 1'b1, 5'd9, 32'h33);
      applyStimulus(3'b001, 1'b1, 3'b001, 32'h280, 1'b1, 5'd7, 32'h11);
      applyStimulus(3'b000, 1'b1, 3'b000, 32'h80, 1'b0, 5'd0, 32'h0);
      applyStimulus(3'b000, 1'b1, 3'b000, 32'h0, 1'b0, 5'd0, 32'h0);

      // wb_en low holds grants and pointer
      setReqs(5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33);
      for (int c = 0; c < 4; c++) begin
         applyStimulus(3'b111, 1'b0, 3'b000, 32'hE, 1'b0, 5'd0, 32'h0);
      end
      applyStimulus(3'b111, 1'b1, 3'b010, 32'hE, 1'b1, 5'd2, 32'h22);
      applyStimulus(3'b101, 1'b1, 3'b100, 32'hE, 1'b1, 5'd3, 32'h33);
      applyStimulus(3'b001, 1'b1, 3'b001, 32'hA, 1'b1, 5'd1, 32'h11);

      // Asynchronous reset with a write to x10 staged
      setReqs(5'd1, 5'd10, 5'd3, 32'h11, 32'hAA, 32'h33);
      applyStimulus(3'b010, 1'b1, 3'b010, 32'h402, 1'b1, 5'd10, 32'hAA);
      req_valid = 3'b111;
      #2 rst_n = 1'b0;
      #1;
      checkOutput("arst_rf_we", 64'(rf_we), 64'h0);
      checkOutput("arst_rf_a3", 64'(rf_a3), 64'h0);
      checkOutput("arst_pending", 64'(pending), 64'h0);
      checkOutput("arst_ready", 64'(req_ready), 64'h0);
      @(negedge clk); #1;
      checkOutput("x10_unchanged", 64'(rfMem[10]), 64'h0);
      req_valid = 3'b000;
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      setReqs(5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33);
      applyStimulus(3'b111, 1'b1, 3'b001, 32'hE, 1'b1, 5'd1, 32'h11);

      checkOutput("x0_still_zero", 64'(rfMem[0]), 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
